// File: rtl/attopu_boot_ctrl.sv
// attopu_boot_ctrl
//   Boot/run sequencer for the attopu core. Keeps the processor in reset while a
//   framed program image arrives over a byte stream, writes the image word by
//   word into instruction memory, verifies an 8-bit additive checksum and then
//   releases the core. A load_req pulse while running re-enters the loader.
//
//   Frame: SYNC, LEN_HI, LEN_LO, LEN x (D_HI, D_LO), CHK
//   CHK = (LEN_HI + LEN_LO + all data bytes) mod 256.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   rx_data/rx_valid   incoming byte stream
//   rx_ready           byte accepted when rx_valid & rx_ready at posedge clk
//   load_req           reload request, honoured only while running
//   imem_we/addr/wdata instruction memory write port ({hi,lo} words)
//   cpu_rst            processor reset (active-high)
//   busy               frame in progress
//   done               image loaded, core running
//   err                last frame failed (length or checksum)
//   words_loaded       words written in the current/last frame
//
// ADDR_W must be 15 or less so that the length fits the 16-bit length field.
module attopu_boot_ctrl #(
    parameter int         ADDR_W = 10,
    parameter logic [7:0] SYNC   = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [3:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_D_HI, S_D_LO, S_WRITE, S_CHK, S_RUN, S_ERR
    } state_t;

    localparam logic [16:0]     MAX_LEN = 17'd1 << ADDR_W;
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [7:0]          len_hi_q, len_hi_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [7:0]          hi_q, hi_d;
    logic [7:0]          acc_q, acc_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [15:0]         imem_wdata_q, imem_wdata_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    // Also serves as the write index: both restart at 0 per frame and advance together.
    logic [ADDR_W:0]     words_q, words_d;

    logic                accept;
    logic [15:0]         len_full;
    logic [ADDR_W:0]     words_inc;

    assign rx_ready  = (state_q != S_WRITE) && (state_q != S_RUN);
    assign accept    = rx_valid && rx_ready;
    assign len_full  = {len_hi_q, rx_data};
    assign words_inc = words_q + ONE;

    always_comb begin
        state_d      = state_q;
        len_hi_d     = len_hi_q;
        len_d        = len_q;
        hi_d         = hi_q;
        acc_d        = acc_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_rst_d    = cpu_rst_q;
        done_d       = done_q;
        err_d        = err_q;
        words_d      = words_q;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (accept && rx_data == SYNC) begin
                    state_d = S_LEN_HI;
                    acc_d   = 8'h00;
                    words_d = '0;
                    err_d   = 1'b0;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_hi_d = rx_data;
                    acc_d    = acc_q + rx_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    acc_d = acc_q + rx_data;
                    len_d = len_full[ADDR_W:0];
                    if ({1'b0, len_full} > MAX_LEN) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_D_HI;
                    end
                end
            end
            S_D_HI: begin
                if (accept) begin
                    hi_d    = rx_data;
                    acc_d   = acc_q + rx_data;
                    state_d = S_D_LO;
                end
            end
            S_D_LO: begin
                // Write strobe is registered here so it is high throughout WRITE.
                if (accept) begin
                    acc_d        = acc_q + rx_data;
                    imem_we_d    = 1'b1;
                    imem_addr_d  = words_q[ADDR_W-1:0];
                    imem_wdata_d = {hi_q, rx_data};
                    state_d      = S_WRITE;
                end
            end
            S_WRITE: begin
                words_d = words_inc;
                state_d = (words_inc == len_q) ? S_CHK : S_D_HI;
            end
            S_CHK: begin
                if (accept) begin
                    if (rx_data == acc_q) begin
                        state_d   = S_RUN;
                        cpu_rst_d = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (load_req) begin
                    state_d   = S_IDLE;
                    cpu_rst_d = 1'b1;
                    done_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) || (state_d == S_D_HI) ||
                 (state_d == S_D_LO) || (state_d == S_WRITE) || (state_d == S_CHK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_hi_q     <= 8'h00;
            len_q        <= '0;
            hi_q         <= 8'h00;
            acc_q        <= 8'h00;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 16'h0000;
            cpu_rst_q    <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            words_q      <= '0;
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            len_q        <= len_d;
            hi_q         <= hi_d;
            acc_q        <= acc_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_rst_q    <= cpu_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            words_q      <= words_d;
        end
    end

    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_rst      = cpu_rst_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_attopu_boot_ctrl.sv
module tb_attopu_boot_ctrl;

    localparam int         ADDR_W = 10;
    localparam logic [7:0] SYNC   = 8'hA5;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              load_req;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    int errors = 0;
    int checks = 0;
    int stall_cnt = 0;
    logic [31:0] exp_q[$];   // expected writes: {6'b0, addr, data}

    attopu_boot_ctrl #(.ADDR_W(ADDR_W), .SYNC(SYNC)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .load_req     (load_req),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && imem_we) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", {6'b0, imem_addr, imem_wdata}, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("wr", {6'b0, imem_addr, imem_wdata}, e);
                $display("write addr=%0d data=%04h", imem_addr, imem_wdata);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte is taken.
    // rx_valid is left high so consecutive bytes form a continuous stream.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (rx_ready) begin
                @(posedge clk);
                @(negedge clk);
                return;
            end
            stall_cnt++;
            @(negedge clk);
        end
        check("rx_timeout", 32'd0, 32'd1);
    endtask

    // Sends a full frame with random data; checksum byte is XORed with chk_xor
    // so a nonzero value produces a corrupt frame. Oversized lengths stop after LEN_LO.
    task automatic send_frame(input logic [15:0] len, input logic [7:0] chk_xor);
        logic [7:0] acc, hi, lo;
        stall_cnt = 0;
        acc = 8'h00;
        send_byte(SYNC);
        send_byte(len[15:8]);
        send_byte(len[7:0]);
        acc = acc + len[15:8] + len[7:0];
        if (len > 16'd1024) begin
            rx_valid = 1'b0;
            return;
        end
        for (int i = 0; i < int'(len); i++) begin
            hi = 8'($urandom);
            lo = 8'($urandom);
            exp_q.push_back({6'b0, 10'(i), hi, lo});
            send_byte(hi);
            send_byte(lo);
            acc = acc + hi + lo;
        end
        send_byte(acc ^ chk_xor);
        rx_valid = 1'b0;
        $display("frame len=%0d chk_xor=%02h done=%0b err=%0b words=%0d stalls=%0d",
                 len, chk_xor, done, err, words_loaded, stall_cnt);
    endtask

    task automatic do_load_req();
        load_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_req = 1'b0;
        check("lr_cpu_rst", 32'(cpu_rst), 32'd1);
        check("lr_done", 32'(done), 32'd0);
        check("lr_rx_ready", 32'(rx_ready), 32'd1);
        $display("load_req -> cpu_rst=%0b done=%0b", cpu_rst, done);
    endtask

    initial begin
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        load_req = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        check("rst_wdata", {6'b0, imem_addr, imem_wdata}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Non-SYNC byte in IDLE is dropped
        send_byte(8'h33);
        rx_valid = 1'b0;
        check("idle_drop_busy", 32'(busy), 32'd0);

        // Two-word frame A5 00 02 12 34 AB CD + checksum (0xC0)
        stall_cnt = 0;
        send_byte(SYNC);
        check("sync_busy", 32'(busy), 32'd1);
        check("sync_cpu_rst", 32'(cpu_rst), 32'd1);
        exp_q.push_back({6'b0, 10'd0, 16'h1234});
        exp_q.push_back({6'b0, 10'd1, 16'hABCD});
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB); send_byte(8'hCD);
        send_byte(8'hC0);
        rx_valid = 1'b0;
        $display("frame 1234/ABCD done=%0b cpu_rst=%0b", done, cpu_rst);
        check("t1_done", 32'(done), 32'd1);
        check("t1_cpu_rst", 32'(cpu_rst), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_rx_ready", 32'(rx_ready), 32'd0);
        check("t1_words", 32'(words_loaded), 32'd2);
        check("t1_stalls", 32'(stall_cnt), 32'd2);
        check("t1_pending", 32'(exp_q.size()), 32'd0);
        do_load_req();

        // Bad checksum -> ERR
        send_frame(16'd2, 8'h01);
        check("t2_err", 32'(err), 32'd1);
        check("t2_cpu_rst", 32'(cpu_rst), 32'd1);
        check("t2_done", 32'(done), 32'd0);
        check("t2_words", 32'(words_loaded), 32'd2);
        check("t2_rx_ready", 32'(rx_ready), 32'd1);

        // Valid frame from ERR clears err
        send_frame(16'd3, 8'h00);
        check("t2b_err", 32'(err), 32'd0);
        check("t2b_done", 32'(done), 32'd1);
        check("t2b_words", 32'(words_loaded), 32'd3);
        do_load_req();

        // Length 0x0401 exceeds the memory: ERR after LEN_LO, no write
        send_frame(16'h0401, 8'h00);
        $display("oversize frame err=%0b busy=%0b", err, busy);
        check("t3_err", 32'(err), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_words", 32'(words_loaded), 32'd0);
        check("t3_cpu_rst", 32'(cpu_rst), 32'd1);

        // Zero-length frame A5 00 00 00 -> RUN without writes
        send_frame(16'd0, 8'h00);
        check("t4_done", 32'(done), 32'd1);
        check("t4_cpu_rst", 32'(cpu_rst), 32'd0);
        check("t4_words", 32'(words_loaded), 32'd0);
        check("t4_stalls", 32'(stall_cnt), 32'd0);
        do_load_req();
        check("t4_busy_idle", 32'(busy), 32'd0);

        // Maximum image with a continuous stream: one stall per word, last at 1023
        send_frame(16'd1024, 8'h00);
        check("t5_done", 32'(done), 32'd1);
        check("t5_words", 32'(words_loaded), 32'd1024);
        check("t5_stalls", 32'(stall_cnt), 32'd1024);
        check("t5_pending", 32'(exp_q.size()), 32'd0);
        do_load_req();

        // Asynchronous reset while waiting in D_LO of word 1
        send_byte(SYNC); send_byte(8'h00); send_byte(8'h02);
        exp_q.push_back({6'b0, 10'd0, 16'h1122});
        send_byte(8'h11); send_byte(8'h22);
        send_byte(8'h33);
        rx_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        $display("async reset busy=%0b wdata=%04h words=%0d", busy, imem_wdata, words_loaded);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_cpu_rst", 32'(cpu_rst), 32'd1);
        check("t6_wdata", 32'(imem_wdata), 32'd0);
        check("t6_words", 32'(words_loaded), 32'd0);
        check("t6_rx_ready", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        check("t6_garbage_busy", 32'(busy), 32'd0);
        send_frame(16'd3, 8'h00);
        check("t6_done", 32'(done), 32'd1);
        check("t6_err", 32'(err), 32'd0);

        repeat (3) @(negedge clk);
        check("final_pending", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
